// File: rtl/pipeline_stage_decode.sv
// pipeline_stage_decode
//
// Decode stage of the 5-stage in-order core. It takes the registered fetch
// result and reads both source operands from the register file. A writeback
// to the same index in the same cycle is bypassed through to the read. The
// stage detects a load-use dependency against the instruction it holds.
// On such a dependency it stalls fetch and sends a bubble to execute. A
// redirect from execute flushes the stage. The result is registered for
// execute.
//
// Optional feature: define DECODE_PERF_COUNTERS_EN to add saturating
// stall and flush performance counters.
//
// Ports:
//   clock, reset            system clock; synchronous active-high reset
//   fetch_*                 registered fetch result (valid, pc, register
//                           indices, operand-use flags, load flag, immediate)
//   jump_enabled            execute redirect this cycle
//   wb_enable/addr/data     writeback port into the register file
//   stall_on_decode         combinational; fetch holds while high
//   dec_*                   registered decode result to execute
//   perf_stall_count        (DECODE_PERF_COUNTERS_EN) cycles with stall high
//   perf_flush_count        (DECODE_PERF_COUNTERS_EN) cycles a valid fetch
//                           result was flushed by a redirect

module pipeline_stage_decode #(
    parameter int REG_COUNT  = 32,
    parameter int DATA_WIDTH = 32,
    localparam int IDX_WIDTH = $clog2(REG_COUNT)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_valid,
    input  logic [DATA_WIDTH-1:0] fetch_pc,
    input  logic [IDX_WIDTH-1:0]  fetch_rs,
    input  logic [IDX_WIDTH-1:0]  fetch_rt,
    input  logic [IDX_WIDTH-1:0]  fetch_rd,
    input  logic                  fetch_reads_rs,
    input  logic                  fetch_reads_rt,
    input  logic                  fetch_writes_reg,
    input  logic                  fetch_is_load,
    input  logic [DATA_WIDTH-1:0] fetch_imm,
    input  logic                  jump_enabled,
    input  logic                  wb_enable,
    input  logic [IDX_WIDTH-1:0]  wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  stall_on_decode,
    output logic                  dec_valid,
    output logic [DATA_WIDTH-1:0] dec_pc,
    output logic [DATA_WIDTH-1:0] dec_rs_value,
    output logic [DATA_WIDTH-1:0] dec_rt_value,
    output logic [DATA_WIDTH-1:0] dec_imm,
    output logic [IDX_WIDTH-1:0]  dec_rd,
    output logic                  dec_writes_reg,
    output logic                  dec_is_load
`ifdef DECODE_PERF_COUNTERS_EN
    ,
    output logic [31:0]           perf_stall_count,
    output logic [31:0]           perf_flush_count
`endif
);

    logic [DATA_WIDTH-1:0] regs [REG_COUNT];
    logic [DATA_WIDTH-1:0] rs_value;
    logic [DATA_WIDTH-1:0] rt_value;
    logic                  hazard;
    logic                  wb_write;

    // Entry 0 is never written, so it stays zero after reset.
    assign wb_write = wb_enable && (wb_addr != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Register 0 reads as zero. The index check also excludes a bypass of
    // a write aimed at r0.
    assign rs_value = (fetch_rs == '0) ? '0 :
                      (wb_enable && (wb_addr == fetch_rs)) ? wb_data :
                      regs[fetch_rs];
    assign rt_value = (fetch_rt == '0) ? '0 :
                      (wb_enable && (wb_addr == fetch_rt)) ? wb_data :
                      regs[fetch_rt];

    // A load sitting in the decode register has no data until the memory
    // stage. A dependent instruction right behind it must wait one cycle.
    // Only the decode register is examined.
    always_comb begin
        hazard = 1'b0;
        if (dec_valid && dec_is_load && dec_writes_reg && (dec_rd != '0) && fetch_valid) begin
            hazard = (fetch_reads_rs && (fetch_rs == dec_rd)) ||
                     (fetch_reads_rt && (fetch_rt == dec_rd));
        end
    end

    // A redirect makes the waiting instruction wrong-path, so it wins over
    // the stall.
    assign stall_on_decode = hazard && !jump_enabled && !reset;

    // Flushes and bubbles zero every field. Execute and memory then never
    // see a stale write enable behind dec_valid=0.
    always_ff @(posedge clock) begin
        if (reset || jump_enabled || hazard || !fetch_valid) begin
            dec_valid      <= 1'b0;
            dec_pc         <= '0;
            dec_rs_value   <= '0;
            dec_rt_value   <= '0;
            dec_imm        <= '0;
            dec_rd         <= '0;
            dec_writes_reg <= 1'b0;
            dec_is_load    <= 1'b0;
        end else begin
            dec_valid      <= 1'b1;
            dec_pc         <= fetch_pc;
            dec_rs_value   <= rs_value;
            dec_rt_value   <= rt_value;
            dec_imm        <= fetch_imm;
            dec_rd         <= fetch_rd;
            dec_writes_reg <= fetch_writes_reg;
            dec_is_load    <= fetch_is_load;
        end
    end

`ifdef DECODE_PERF_COUNTERS_EN
    // Both counters stick at all-ones instead of wrapping.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_count <= '0;
            perf_flush_count <= '0;
        end else begin
            if (stall_on_decode && (perf_stall_count != '1)) begin
                perf_stall_count <= perf_stall_count + 32'd1;
            end
            if (jump_enabled && fetch_valid && (perf_flush_count != '1)) begin
                perf_flush_count <= perf_flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stage_decode.sv
// tb_pipeline_stage_decode
//
// Self-checking bench for pipeline_stage_decode. Directed scenarios are
// followed by a randomized run. A behavioural model of the decode stage
// runs beside the DUT. It holds an array register file and a record of the
// instruction issued to execute.

module tb_pipeline_stage_decode;

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [4:0]  fetch_rs;
    logic [4:0]  fetch_rt;
    logic [4:0]  fetch_rd;
    logic        fetch_reads_rs;
    logic        fetch_reads_rt;
    logic        fetch_writes_reg;
    logic        fetch_is_load;
    logic [31:0] fetch_imm;
    logic        jump_enabled;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall_on_decode;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [31:0] dec_rs_value;
    logic [31:0] dec_rt_value;
    logic [31:0] dec_imm;
    logic [4:0]  dec_rd;
    logic        dec_writes_reg;
    logic        dec_is_load;
`ifdef DECODE_PERF_COUNTERS_EN
    logic [31:0] perf_stall_count;
    logic [31:0] perf_flush_count;
`endif

    int checks;
    int failures;

    // Reference model state.
    logic [31:0]  m_rf [32];
    logic [135:0] m_dec;
    logic         m_stall;
    logic [31:0]  m_stall_cnt;
    logic [31:0]  m_flush_cnt;

    pipeline_stage_decode dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_pc         (fetch_pc),
        .fetch_rs         (fetch_rs),
        .fetch_rt         (fetch_rt),
        .fetch_rd         (fetch_rd),
        .fetch_reads_rs   (fetch_reads_rs),
        .fetch_reads_rt   (fetch_reads_rt),
        .fetch_writes_reg (fetch_writes_reg),
        .fetch_is_load    (fetch_is_load),
        .fetch_imm        (fetch_imm),
        .jump_enabled     (jump_enabled),
        .wb_enable        (wb_enable),
        .wb_addr          (wb_addr),
        .wb_data          (wb_data),
        .stall_on_decode  (stall_on_decode),
        .dec_valid        (dec_valid),
        .dec_pc           (dec_pc),
        .dec_rs_value     (dec_rs_value),
        .dec_rt_value     (dec_rt_value),
        .dec_imm          (dec_imm),
        .dec_rd           (dec_rd),
        .dec_writes_reg   (dec_writes_reg),
        .dec_is_load      (dec_is_load)
`ifdef DECODE_PERF_COUNTERS_EN
        ,
        .perf_stall_count (perf_stall_count),
        .perf_flush_count (perf_flush_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [135:0] dut_dec();
        return {dec_valid, dec_pc, dec_rs_value, dec_rt_value, dec_imm,
                dec_rd, dec_writes_reg, dec_is_load};
    endfunction

    // Architectural read as seen this cycle: r0 is zero, and a pending
    // writeback to the same register is visible.
    function automatic logic [31:0] model_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_enable && wb_addr == idx) return wb_data;
        return m_rf[idx];
    endfunction

    // Would the instruction at fetch use the result of the load held in
    // the model's issued record?
    function automatic logic model_load_use();
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        v  = m_dec[135];
        rd = m_dec[6:2];
        wr = m_dec[1];
        ld = m_dec[0];
        return v && ld && wr && rd != 5'd0 && fetch_valid &&
               ((fetch_reads_rs && fetch_rs == rd) || (fetch_reads_rt && fetch_rt == rd));
    endfunction

    // Refresh the combinational expectation after driving inputs.
    task automatic settle();
        #1;
        m_stall = model_load_use() && !jump_enabled && !reset;
    endtask

    // Advance the model and the DUT one clock. Outputs are then sampled
    // 1 time unit after the edge.
    task automatic cycle();
        logic         haz;
        logic [135:0] nxt;
        haz = model_load_use();
        if (reset || jump_enabled || haz || !fetch_valid)
            nxt = '0;
        else
            nxt = {1'b1, fetch_pc, model_read(fetch_rs), model_read(fetch_rt),
                   fetch_imm, fetch_rd, fetch_writes_reg, fetch_is_load};
        if (reset) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        end else begin
            if (haz && !jump_enabled && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
            if (jump_enabled && fetch_valid && m_flush_cnt != 32'hFFFF_FFFF) m_flush_cnt++;
            if (wb_enable && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        end
        m_dec = nxt;
        @(posedge clock);
        #1;
        m_stall = model_load_use() && !jump_enabled && !reset;
    endtask

    task automatic idle_inputs();
        reset            = 1'b0;
        fetch_valid      = 1'b0;
        fetch_pc         = '0;
        fetch_rs         = '0;
        fetch_rt         = '0;
        fetch_rd         = '0;
        fetch_reads_rs   = 1'b0;
        fetch_reads_rt   = 1'b0;
        fetch_writes_reg = 1'b0;
        fetch_is_load    = 1'b0;
        fetch_imm        = '0;
        jump_enabled     = 1'b0;
        wb_enable        = 1'b0;
        wb_addr          = '0;
        wb_data          = '0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [31:0] pc);
        idle_inputs();
        fetch_valid      = 1'b1;
        fetch_pc         = pc;
        fetch_rd         = rd;
        fetch_writes_reg = 1'b1;
        fetch_is_load    = 1'b1;
    endtask

    task automatic drive_reader(input logic [4:0] rs, input logic [31:0] pc);
        idle_inputs();
        fetch_valid    = 1'b1;
        fetch_pc       = pc;
        fetch_rs       = rs;
        fetch_reads_rs = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        fetch_valid = 1'b1;
        fetch_pc    = 32'hABCD;
        reset       = 1'b1;
        settle();
        checks++;
        if (stall_on_decode !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_stall got=%b want=0", stall_on_decode);
        end
        cycle();
        cycle();
        checks++;
        if (dut_dec() !== 136'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%h want=0", dut_dec());
        end
        reset = 1'b0;
    endtask

    task automatic test_basic_read();
        idle_inputs();
        wb_enable = 1'b1;
        wb_addr   = 5'd3;
        wb_data   = 32'hDEAD;
        cycle();
        drive_reader(5'd3, 32'h10);
        cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h10 || dec_rs_value !== 32'hDEAD) begin
            failures++;
            $display("[TB] FAIL basic_read got valid=%b pc=%h rs=%h want 1/10/dead",
                     dec_valid, dec_pc, dec_rs_value);
        end
    endtask

    task automatic test_bypass();
        idle_inputs();
        fetch_valid    = 1'b1;
        fetch_pc       = 32'h20;
        fetch_rt       = 5'd5;
        fetch_reads_rt = 1'b1;
        wb_enable      = 1'b1;
        wb_addr        = 5'd5;
        wb_data        = 32'h1234;
        cycle();
        checks++;
        if (dec_rt_value !== 32'h1234) begin
            failures++;
            $display("[TB] FAIL bypass_rt got=%h want=1234", dec_rt_value);
        end
        // Write r0 while reading it: neither bypass nor storage may expose it.
        idle_inputs();
        fetch_valid    = 1'b1;
        fetch_pc       = 32'h24;
        fetch_reads_rs = 1'b1;
        fetch_reads_rt = 1'b1;
        fetch_rt       = 5'd5;
        wb_enable      = 1'b1;
        wb_addr        = 5'd0;
        wb_data        = 32'hFFFF;
        cycle();
        checks++;
        if (dec_rs_value !== 32'd0 || dec_rt_value !== 32'h1234) begin
            failures++;
            $display("[TB] FAIL r0_write_bypass got rs=%h rt=%h want 0/1234", dec_rs_value, dec_rt_value);
        end
        idle_inputs();
        fetch_valid    = 1'b1;
        fetch_reads_rs = 1'b1;
        cycle();
        checks++;
        if (dec_rs_value !== 32'd0) begin
            failures++;
            $display("[TB] FAIL r0_stored got=%h want=0", dec_rs_value);
        end
    endtask

    task automatic test_load_use();
        drive_load(5'd7, 32'h40);
        cycle();
        drive_reader(5'd7, 32'h44);
        settle();
        checks++;
        if (stall_on_decode !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_use_stall got=%b want=1", stall_on_decode);
        end
        cycle();
        checks++;
        if (dec_valid !== 1'b0 || stall_on_decode !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_use_bubble got valid=%b stall=%b want 0/0", dec_valid, stall_on_decode);
        end
        cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h44) begin
            failures++;
            $display("[TB] FAIL load_use_issue got valid=%b pc=%h want 1/44", dec_valid, dec_pc);
        end
    endtask

    task automatic test_no_hazard();
        drive_load(5'd7, 32'h50);
        cycle();
        drive_reader(5'd8, 32'h54);
        settle();
        checks++;
        if (stall_on_decode !== 1'b0) begin
            failures++;
            $display("[TB] FAIL other_reg_stall got=%b want=0", stall_on_decode);
        end
        drive_load(5'd7, 32'h58);
        fetch_is_load = 1'b0;
        cycle();
        drive_reader(5'd7, 32'h5C);
        settle();
        checks++;
        if (stall_on_decode !== 1'b0) begin
            failures++;
            $display("[TB] FAIL non_load_stall got=%b want=0", stall_on_decode);
        end
        cycle();
        checks++;
        if (dec_valid !== 1'b1 || dec_pc !== 32'h5C) begin
            failures++;
            $display("[TB] FAIL non_load_issue got valid=%b pc=%h want 1/5c", dec_valid, dec_pc);
        end
    endtask

    task automatic test_jump_over_hazard();
        logic [31:0] s0;
        logic [31:0] f0;
        s0 = m_stall_cnt;
        f0 = m_flush_cnt;
        drive_load(5'd7, 32'h60);
        cycle();
        drive_reader(5'd7, 32'h64);
        jump_enabled = 1'b1;
        settle();
        checks++;
        if (stall_on_decode !== 1'b0) begin
            failures++;
            $display("[TB] FAIL jump_stall got=%b want=0", stall_on_decode);
        end
        cycle();
        checks++;
        if (dut_dec() !== 136'd0) begin
            failures++;
            $display("[TB] FAIL jump_flush got=%h want=0", dut_dec());
        end
`ifdef DECODE_PERF_COUNTERS_EN
        checks++;
        if (perf_flush_count !== f0 + 32'd1 || perf_stall_count !== s0) begin
            failures++;
            $display("[TB] FAIL jump_perf got flush=%0d stall=%0d want %0d/%0d",
                     perf_flush_count, perf_stall_count, f0 + 32'd1, s0);
        end
`else
        if (m_flush_cnt !== f0 + 32'd1 || m_stall_cnt !== s0)
            $display("[TB] note: model counters off (flush %0d stall %0d)", m_flush_cnt, m_stall_cnt);
`endif
    endtask

    task automatic test_reset_mid_stall();
        drive_load(5'd7, 32'h70);
        cycle();
        drive_reader(5'd7, 32'h74);
        settle();
        checks++;
        if (stall_on_decode !== 1'b1) begin
            failures++;
            $display("[TB] FAIL pre_reset_stall got=%b want=1", stall_on_decode);
        end
        reset = 1'b1;
        settle();
        checks++;
        if (stall_on_decode !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_drops_stall got=%b want=0", stall_on_decode);
        end
        cycle();
        checks++;
        if (dut_dec() !== 136'd0) begin
            failures++;
            $display("[TB] FAIL reset_mid_outputs got=%h want=0", dut_dec());
        end
        // r3 held 0xDEAD before reset.
        drive_reader(5'd3, 32'h78);
        fetch_reads_rt = 1'b1;
        fetch_rt       = 5'd5;
        cycle();
        checks++;
        if (dec_rs_value !== 32'd0 || dec_rt_value !== 32'd0 || dec_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_clears_rf got rs=%h rt=%h valid=%b want 0/0/1",
                     dec_rs_value, dec_rt_value, dec_valid);
        end
    endtask

    task automatic test_random();
        int bad;
        int last_stall;
        bad = 0;
        last_stall = 0;
        for (int n = 0; n < 600; n++) begin
            idle_inputs();
            reset            = ($urandom_range(0, 49) == 0);
            fetch_valid      = ($urandom_range(0, 9) < 8);
            fetch_pc         = $urandom;
            fetch_rs         = 5'($urandom_range(0, 7));
            fetch_rt         = 5'($urandom_range(0, 7));
            fetch_rd         = 5'($urandom_range(0, 7));
            fetch_reads_rs   = 1'($urandom);
            fetch_reads_rt   = 1'($urandom);
            fetch_writes_reg = ($urandom_range(0, 3) != 0);
            fetch_is_load    = ($urandom_range(0, 9) < 4);
            fetch_imm        = $urandom;
            jump_enabled     = ($urandom_range(0, 9) == 0);
            wb_enable        = 1'($urandom);
            wb_addr          = 5'($urandom_range(0, 7));
            wb_data          = $urandom;
            settle();
            checks++;
            if (stall_on_decode !== m_stall) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("[TB] FAIL random_stall n=%0d got=%b want=%b", n, stall_on_decode, m_stall);
            end
            if (last_stall != 0 && m_stall) begin
                failures++;
                $display("[TB] FAIL random_stall_run n=%0d stall two cycles in a row", n);
            end
            last_stall = int'(m_stall);
            cycle();
            checks++;
            if (dut_dec() !== m_dec) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("[TB] FAIL random_dec n=%0d got=%h want=%h", n, dut_dec(), m_dec);
            end
`ifdef DECODE_PERF_COUNTERS_EN
            checks++;
            if (perf_stall_count !== m_stall_cnt || perf_flush_count !== m_flush_cnt) begin
                failures++;
                bad++;
                if (bad < 10)
                    $display("[TB] FAIL random_perf n=%0d got=%0d/%0d want=%0d/%0d", n,
                             perf_stall_count, perf_flush_count, m_stall_cnt, m_flush_cnt);
            end
`endif
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        m_dec       = '0;
        m_stall     = 1'b0;
        m_stall_cnt = '0;
        m_flush_cnt = '0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        idle_inputs();
        test_reset();
        test_basic_read();
        test_bypass();
        test_load_use();
        test_no_hazard();
        test_jump_over_hazard();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
